// File: rtl/mmio_port_responder_pkg.sv
// rtl/mmio_port_responder_pkg.sv - shared offsets, bit indices and defaults for the MMIO port responder
package mmio_port_responder_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0040;

  localparam logic [4:0] OFF_OUT    = 5'h00;
  localparam logic [4:0] OFF_IN     = 5'h04;
  localparam logic [4:0] OFF_STATUS = 5'h08;
  localparam logic [4:0] OFF_COUNT  = 5'h0C;
  localparam logic [4:0] OFF_CTRL   = 5'h10;

  localparam int STATUS_CHG     = 0;
  localparam int STATUS_OVF     = 1;
  localparam int STATUS_CLR_CNT = 2;

  localparam int CTRL_IE        = 0;
  localparam int CTRL_CLR_ON_RD = 1;

  // A register exists at word-aligned offsets up to and including CTRL.
  function automatic logic reg_exists(logic [4:0] off);
    return (off[1:0] == 2'b00) && (off <= OFF_CTRL);
  endfunction

endpackage

// File: rtl/mmio_port_responder_if.sv
// rtl/mmio_port_responder_if.sv - data-memory bus bundle between processor and I/O responder
interface mmio_port_responder_if;

  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  ReadData, Hit
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output ReadData, Hit
  );

endinterface

// File: rtl/mmio_port_responder_sync_edge_detect.sv
// rtl/mmio_port_responder_sync_edge_detect.sv - three-flop input synchroniser with change detection
module mmio_port_responder_sync_edge_detect #(
  parameter int IN_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] async_in,
  output logic [IN_WIDTH-1:0] sync_out,
  output logic                change_evt
);

  logic [IN_WIDTH-1:0] ff1_q, ff1_d;
  logic [IN_WIDTH-1:0] ff2_q, ff2_d;
  logic [IN_WIDTH-1:0] ff3_q, ff3_d;

  // Shift the pins one stage per clock; ff1 may be metastable, so only ff2/ff3 are observed.
  always_comb begin
    ff1_d = async_in;
    ff2_d = ff1_q;
    ff3_d = ff2_q;
  end

  // Synchroniser stages, cleared so a held nonzero input yields one event after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff1_q <= '0;
      ff2_q <= '0;
      ff3_q <= '0;
    end else begin
      ff1_q <= ff1_d;
      ff2_q <= ff2_d;
      ff3_q <= ff3_d;
    end
  end

  assign sync_out   = ff2_q;
  assign change_evt = (ff2_q != ff3_q);

endmodule

// File: rtl/mmio_port_responder.sv
// rtl/mmio_port_responder.sv - memory-mapped I/O port with change flags, edge counter and interrupt
module mmio_port_responder
  import mmio_port_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          IN_WIDTH  = 8,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  mmio_port_responder_if.slave bus,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                IrqOut
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [4:0]           offset;
  logic                 hit;
  logic                 wr_en;
  logic                 rd_en;
  logic [IN_WIDTH-1:0]  sync_in;
  logic                 change_evt;

  logic [31:0]          out_q, out_d;
  logic                 chg_q, chg_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 ie_q, ie_d;
  logic                 clr_on_rd_q, clr_on_rd_d;

  logic                 sts_wr;
  logic                 clr_chg;
  logic                 clr_ovf;
  logic                 clr_cnt;
  logic [31:0]          rdata;

  mmio_port_responder_sync_edge_detect #(
    .IN_WIDTH (IN_WIDTH)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .async_in   (PortIn),
    .sync_out   (sync_in),
    .change_evt (change_evt)
  );

  assign offset = bus.Address[4:0];
  assign hit    = (bus.Address[31:5] == BASE_ADDR[31:5]) && reg_exists(offset);
  assign wr_en  = bus.MemWrite & hit;
  assign rd_en  = bus.MemRead & hit;

  // Combinational load data from current state; a simultaneous store still returns the old value.
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (offset)
        OFF_OUT:    rdata = out_q;
        OFF_IN:     rdata = 32'(sync_in);
        OFF_STATUS: rdata = {30'b0, ovf_q, chg_q};
        OFF_COUNT:  rdata = 32'(count_q);
        OFF_CTRL:   rdata = {30'b0, clr_on_rd_q, ie_q};
        default:    rdata = '0;
      endcase
    end
  end

  // Next register state: stores, read-clear of STATUS, and change events (set beats clear).
  always_comb begin
    sts_wr  = wr_en && (offset == OFF_STATUS);
    clr_chg = (sts_wr && bus.WriteData[STATUS_CHG]) ||
              (rd_en && (offset == OFF_STATUS) && clr_on_rd_q);
    clr_ovf = (sts_wr && bus.WriteData[STATUS_OVF]) ||
              (rd_en && (offset == OFF_STATUS) && clr_on_rd_q);
    clr_cnt = sts_wr && bus.WriteData[STATUS_CLR_CNT];

    out_d       = out_q;
    ie_d        = ie_q;
    clr_on_rd_d = clr_on_rd_q;
    if (wr_en && (offset == OFF_OUT)) begin
      out_d = bus.WriteData;
    end
    if (wr_en && (offset == OFF_CTRL)) begin
      ie_d        = bus.WriteData[CTRL_IE];
      clr_on_rd_d = bus.WriteData[CTRL_CLR_ON_RD];
    end

    chg_d = change_evt | (chg_q & ~clr_chg);
    // A counter clear in the same edge restarts from zero, so it cannot overflow.
    ovf_d = (change_evt & ~clr_cnt & (&count_q)) | (ovf_q & ~clr_ovf);

    if (clr_cnt) begin
      count_d = change_evt ? CNT_ONE : '0;
    end else if (change_evt) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Register file with asynchronous clear so a reset mid-access drops all state immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q       <= '0;
      chg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      ie_q        <= 1'b0;
      clr_on_rd_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      chg_q       <= chg_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      ie_q        <= ie_d;
      clr_on_rd_q <= clr_on_rd_d;
    end
  end

  assign bus.ReadData = rdata;
  assign bus.Hit      = hit;
  assign PortOut      = out_q;
  assign IrqOut       = chg_q & ie_q;

endmodule
